// File: rtl/rtype_encoder.sv
// RV32I R-type instruction encoder: (alu_op, rd, rs1, rs2) requests in, addressed 32-bit words out
// through a small FIFO, with emitted/rejected request counters and a sticky error flag.
module rtype_encoder #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_op,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [31:0]      out_addr,
  output logic [CNT_W-1:0] emitted_cnt,
  output logic [7:0]       illegal_cnt,
  output logic             err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [6:0] OPCODE_OP = 7'b0110011;

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_SLL = 4'b0011,
    OP_SUB = 4'b0100,
    OP_SRL = 4'b0101,
    OP_SLT = 4'b0110,
    OP_XOR = 4'b0111
  } alu_op_e;

  logic [6:0]  func7;
  logic [2:0]  func3;
  logic        legal;
  logic [31:0] word;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    func7 = 7'd0;
    func3 = 3'd0;
    legal = 1'b1;
    case (alu_op)
      OP_AND:  func3 = 3'd7;
      OP_OR:   func3 = 3'd6;
      OP_ADD:  func3 = 3'd0;
      OP_SLL:  func3 = 3'd1;
      OP_SUB:  func7 = 7'd32;
      OP_SRL:  func3 = 3'd5;
      OP_SLT:  func3 = 3'd2;
      OP_XOR:  func3 = 3'd4;
      default: legal = 1'b0;
    endcase
  end

  assign word = {func7, rs2, rs1, func3, rd, OPCODE_OP};

  logic [31:0] mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        empty;
  logic        full;
  logic        accept;
  logic        push;
  logic        take;

  // Extra wrap bit distinguishes full from empty when the index bits match.
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign accept    = in_valid && in_ready;
  assign push      = accept && legal;
  assign take      = out_valid && out_ready;

  // Storage is never read unless written, so masking the head while empty keeps out_instr X-free.
  assign out_instr = empty ? 32'd0 : mem[rd_ptr[AW-1:0]];

  // NOTE: the FIFO array has no reset; pointers alone define validity, so the storage stays plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= word;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      out_addr    <= BASE_ADDR;
      emitted_cnt <= '0;
      illegal_cnt <= 8'd0;
      err         <= 1'b0;
    end else if (restart) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      out_addr    <= BASE_ADDR;
      emitted_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (take) begin
        rd_ptr      <= rd_ptr + 1'b1;
        out_addr    <= out_addr + 32'd4;
        emitted_cnt <= emitted_cnt + 1'b1;
      end
      if (accept && !legal) begin
        if (illegal_cnt != 8'hFF) illegal_cnt <= illegal_cnt + 1'b1;
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rtype_encoder.sv
// Scoreboard bench for rtype_encoder: stimulus queues expected words, a forked monitor checks
// every word the consumer takes; directed checks cover reset, backpressure, illegal ops, restart.
module tb_rtype_encoder;

  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             restart;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_op;
  logic [4:0]       rd;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic [31:0]      out_addr;
  logic [CNT_W-1:0] emitted_cnt;
  logic [7:0]       illegal_cnt;
  logic             err;

  rtype_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .restart(restart),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .rd(rd), .rs1(rs1), .rs2(rs2),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr),
    .emitted_cnt(emitted_cnt), .illegal_cnt(illegal_cnt), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
  } exp_t;

  exp_t sb_q[$];
  int   total    = 0;
  int   bad      = 0;
  int   addr_idx = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ADD with rs1 = rs2 = x0: only rd and the opcode are non-zero.
  function automatic logic [31:0] hw(input int i);
    return (32'(i) << 7) | 32'h0000_0033;
  endfunction

  task automatic send(input logic [3:0] op, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [31:0] exp_word, input logic legal);
    int n = 0;
    in_valid = 1'b1;
    alu_op   = op;
    rd       = d;
    rs1      = s1;
    rs2      = s2;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b0;
      return;
    end
    if (legal) begin
      sb_q.push_back('{instr: exp_word, addr: BASE + 32'(4 * addr_idx)});
      addr_idx++;
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb_q.size() != 0 || out_valid) && n < 100) begin
      step();
      n++;
    end
    check("drain_out_valid", {31'd0, out_valid}, 32'd0);
    check("drain_queue", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic do_restart();
    restart = 1'b1;
    sb_q.delete();
    addr_idx = 0;
    step();
    restart = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sb_q.delete();
    addr_idx = 0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && !restart && out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("spurious_word", out_instr, 32'hxxxx_xxxx);
        end else begin
          e = sb_q.pop_front();
          check("word_instr", out_instr, e.instr);
          check("word_addr", out_addr, e.addr);
        end
      end
    end
  endtask

  logic [3:0]  sw_op   [8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b0111};
  logic [31:0] sw_word [8] = '{32'h003170B3, 32'h003160B3, 32'h003100B3, 32'h003110B3,
                               32'h403100B3, 32'h003150B3, 32'h003120B3, 32'h003140B3};

  initial begin
    #200000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    int drained;
    rst = 1'b1; restart = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    alu_op = 4'd0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
    fork
      monitor();
    join_none
    do_reset();

    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_out_addr", out_addr, BASE);
    check("rst_emitted", 32'(emitted_cnt), 32'd0);
    check("rst_illegal", 32'(illegal_cnt), 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);

    // Single ADD: visible the cycle after acceptance.
    out_ready = 1'b1;
    send(4'b0010, 5'd3, 5'd1, 5'd2, 32'h002081B3, 1'b1);
    check("add_latency_valid", {31'd0, out_valid}, 32'd1);
    drain();
    check("add_emitted", 32'(emitted_cnt), 32'd1);

    // SUB and a sweep of every legal op (rd=1, rs1=2, rs2=3), back to back.
    send(4'b0100, 5'd5, 5'd6, 5'd7, 32'h407302B3, 1'b1);
    for (int i = 0; i < 8; i++) send(sw_op[i], 5'd1, 5'd2, 5'd3, sw_word[i], 1'b1);
    drain();
    check("sweep_emitted", 32'(emitted_cnt), 32'd10);

    // Backpressure from a fresh address base.
    do_restart();
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send(4'b0010, 5'(i), 5'd0, 5'd0, hw(i), 1'b1);
    check("bp_full_in_ready", {31'd0, in_ready}, 32'd0);
    check("bp_head_instr", out_instr, hw(1));
    check("bp_head_addr", out_addr, BASE);
    in_valid = 1'b1; alu_op = 4'b0010; rd = 5'd5; rs1 = 5'd0; rs2 = 5'd0;
    step();
    step();
    check("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
    check("bp_hold_instr", out_instr, hw(1));
    out_ready = 1'b1;
    send(4'b0010, 5'd5, 5'd0, 5'd0, hw(5), 1'b1);
    drain();
    check("bp_emitted", 32'(emitted_cnt), 32'd5);
    check("bp_final_addr", out_addr, BASE + 32'd20);

    // Illegal ops: consumed, counted, saturating.
    send(4'b1010, 5'd1, 5'd1, 5'd1, 32'd0, 1'b0);
    check("ill_out_valid", {31'd0, out_valid}, 32'd0);
    check("ill_cnt_one", 32'(illegal_cnt), 32'd1);
    check("ill_err", {31'd0, err}, 32'd1);
    in_valid = 1'b1; alu_op = 4'b1111;
    repeat (300) step();
    in_valid = 1'b0;
    check("ill_cnt_sat", 32'(illegal_cnt), 32'd255);
    check("ill_no_word", {31'd0, out_valid}, 32'd0);

    // Concurrent accept and take with two words resident.
    out_ready = 1'b0;
    send(4'b0010, 5'd1, 5'd0, 5'd0, hw(1), 1'b1);
    send(4'b0010, 5'd2, 5'd0, 5'd0, hw(2), 1'b1);
    out_ready = 1'b1;
    for (int i = 3; i <= 12; i++) begin
      check("cc_in_ready", {31'd0, in_ready}, 32'd1);
      send(4'b0010, 5'(i), 5'd0, 5'd0, hw(i), 1'b1);
    end
    drained = 0;
    for (int n = 0; n < 20; n++) begin
      if (out_valid && out_ready) drained++;
      step();
    end
    check("cc_occupancy", 32'(drained), 32'd2);
    check("cc_queue_empty", 32'(sb_q.size()), 32'd0);

    // Restart with words pending: discarded, counters except illegal/err cleared.
    out_ready = 1'b0;
    for (int i = 7; i <= 9; i++) send(4'b0010, 5'(i), 5'd0, 5'd0, hw(i), 1'b1);
    check("rs_pre_valid", {31'd0, out_valid}, 32'd1);
    do_restart();
    check("rs_out_valid", {31'd0, out_valid}, 32'd0);
    check("rs_out_addr", out_addr, BASE);
    check("rs_emitted", 32'(emitted_cnt), 32'd0);
    check("rs_err_held", {31'd0, err}, 32'd1);
    check("rs_illegal_held", 32'(illegal_cnt), 32'd255);
    out_ready = 1'b1;
    send(4'b0111, 5'd1, 5'd2, 5'd3, 32'h003140B3, 1'b1);
    drain();
    check("rs_emitted_after", 32'(emitted_cnt), 32'd1);

    do_reset();
    check("rst2_err", {31'd0, err}, 32'd0);
    check("rst2_illegal", 32'(illegal_cnt), 32'd0);
    check("rst2_out_addr", out_addr, BASE);
    check("rst2_emitted", 32'(emitted_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
